// File: rtl/caches_pkg.sv
// Shared cache types and defaults: frame layout, fill FSM states, set count.
package caches_pkg;

    localparam int ICACHE_SETS    = 16;
    // Tag field sized for the smallest legal cache (2 sets) so any power-of-2
    // SETS fits; unused upper tag bits are stored and compared as zero.
    localparam int ICACHE_TAG_W   = 29;
    localparam int ICACHE_WORD_W  = 32;

    typedef struct packed {
        logic                     valid;
        logic [ICACHE_TAG_W-1:0]  tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc32 = value;
        end else begin
            sat_inc32 = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one combinational read port, one synchronous
// write port, and a global valid clear that a same-edge write overrides.
module icache_frame_array
    import caches_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [IDX_W-1:0]        idx,
    output icache_frame_t           rframe,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  icache_frame_t           wframe
);

    logic [SETS-1:0]          valid_r;
    logic [ICACHE_TAG_W-1:0]  tag_r  [SETS];
    logic [ICACHE_WORD_W-1:0] data_r [SETS];

    // Valid bits: reset and clear wipe all frames, a write then re-sets its own frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else begin
            if (clr) begin
                valid_r <= '0;
            end
            if (we) begin
                valid_r[widx] <= wframe.valid;
            end
        end
    end

    // Tag and data payload; contents are meaningless while the valid bit is 0.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_r[widx]  <= wframe.tag;
            data_r[widx] <= wframe.data;
        end
    end

    // Combinational read of the indexed frame.
    always_comb begin
        rframe.valid = valid_r[idx];
        rframe.tag   = tag_r[idx];
        rframe.data  = data_r[idx];
    end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: same-cycle hits, single-word fill on miss,
// saturating hit/miss counters.
module icache_direct_mapped
    import caches_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dp_imemREN,
    input  logic [31:0]       dp_imemaddr,
    output logic              dp_ihit,
    output logic [31:0]       dp_imemload,
    input  logic              inv,
    output logic              mem_iREN,
    output logic [31:0]       mem_iaddr,
    input  logic              mem_iwait,
    input  logic [31:0]       mem_iload,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(SETS);

    icache_state_t     state_r;
    logic [31:0]       miss_addr_r;
    logic [CNT_W-1:0]  hit_count_r;
    logic [CNT_W-1:0]  miss_count_r;

    logic [IDX_W-1:0]        idx_s;
    logic [ICACHE_TAG_W-1:0] tag_s;
    logic [IDX_W-1:0]        fill_idx_s;
    logic [ICACHE_TAG_W-1:0] fill_tag_s;
    icache_frame_t           rframe_s;
    icache_frame_t           wframe_s;
    logic                    hit_s;
    logic                    fill_we_s;

    // Saturating increment at the configured counter width.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            cnt_inc = value;
        end else begin
            cnt_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Address split for the lookup and for the pending fill.
    always_comb begin
        idx_s      = dp_imemaddr[IDX_W+1:2];
        tag_s      = ICACHE_TAG_W'(dp_imemaddr[31:IDX_W+2]);
        fill_idx_s = miss_addr_r[IDX_W+1:2];
        fill_tag_s = ICACHE_TAG_W'(miss_addr_r[31:IDX_W+2]);
    end

    // Hit detection and fetch-side outputs; no bypass of fill data during FETCH.
    always_comb begin
        hit_s = (state_r == IDLE) && dp_imemREN && rframe_s.valid && (rframe_s.tag == tag_s);
        if (hit_s) begin
            dp_imemload = rframe_s.data;
        end else begin
            dp_imemload = 32'h0000_0000;
        end
        dp_ihit    = hit_s;
        mem_iREN   = (state_r == FETCH);
        mem_iaddr  = miss_addr_r;
        hit_count  = hit_count_r;
        miss_count = miss_count_r;
    end

    // Fill write: completes when memory drops iwait; a reset on that edge abandons it.
    always_comb begin
        fill_we_s      = (state_r == FETCH) && !mem_iwait && !RST;
        wframe_s.valid = 1'b1;
        wframe_s.tag   = fill_tag_s;
        wframe_s.data  = mem_iload;
    end

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_frames (
        .clk    (CLK),
        .rst    (RST),
        .clr    (inv),
        .idx    (idx_s),
        .rframe (rframe_s),
        .we     (fill_we_s),
        .widx   (fill_idx_s),
        .wframe (wframe_s)
    );

    // Miss/fill FSM with miss address latch and performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            miss_addr_r  <= 32'h0000_0000;
            hit_count_r  <= '0;
            miss_count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s) begin
                        hit_count_r <= cnt_inc(hit_count_r);
                    end else if (dp_imemREN) begin
                        miss_addr_r  <= dp_imemaddr;
                        miss_count_r <= cnt_inc(miss_count_r);
                        state_r      <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (!mem_iwait) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural cache model.
module tb_icache_direct_mapped;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        dp_imemREN = 1'b0;
    logic [31:0] dp_imemaddr = 32'h0;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        inv = 1'b0;
    logic        mem_iREN;
    logic [31:0] mem_iaddr;
    logic        mem_iwait = 1'b1;
    logic [31:0] mem_iload = 32'h0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int num_tests = 0;
    int num_fail  = 0;
    bit chk_en    = 1'b0;

    // Behavioural model: one entry per set, plus "waiting on memory" and the miss address.
    bit          m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_busy  = 1'b0;
    logic [31:0] m_maddr = 32'h0;
    logic [31:0] m_hits  = 32'h0;
    logic [31:0] m_miss  = 32'h0;

    always #5 CLK = ~CLK;

    icache_direct_mapped #(.SETS(SETS), .CNT_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .dp_imemREN  (dp_imemREN),
        .dp_imemaddr (dp_imemaddr),
        .dp_ihit     (dp_ihit),
        .dp_imemload (dp_imemload),
        .inv         (inv),
        .mem_iREN    (mem_iREN),
        .mem_iaddr   (mem_iaddr),
        .mem_iwait   (mem_iwait),
        .mem_iload   (mem_iload),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_tests++;
        if (got !== exp) begin
            num_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 32'd4) % SETS);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (SETS * 4);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One clock cycle: drive, check model expectations mid-cycle, advance model at the edge.
    task automatic cycle(input logic ren, input logic [31:0] addr, input logic inv_i,
                         input logic rst_i, input logic iwait, input logic [31:0] iload);
        bit e_hit;
        int s;
        dp_imemREN  = ren;
        dp_imemaddr = addr;
        inv         = inv_i;
        RST         = rst_i;
        mem_iwait   = iwait;
        mem_iload   = iload;
        s = set_of(addr);
        e_hit = !m_busy && ren && m_valid[s] && (m_tag[s] == tag_of(addr));
        @(negedge CLK);
        if (chk_en) begin
            check_eq("dp_ihit", {31'd0, dp_ihit}, {31'd0, e_hit});
            check_eq("dp_imemload", dp_imemload, e_hit ? m_data[s] : 32'h0);
            check_eq("mem_iREN", {31'd0, mem_iREN}, {31'd0, m_busy});
            check_eq("mem_iaddr", mem_iaddr, m_maddr);
            check_eq("hit_count", hit_count, m_hits);
            check_eq("miss_count", miss_count, m_miss);
        end
        @(posedge CLK);
        if (rst_i) begin
            for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            m_busy  = 1'b0;
            m_maddr = 32'h0;
            m_hits  = 32'h0;
            m_miss  = 32'h0;
        end else begin
            if (inv_i) begin
                for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            end
            if (m_busy) begin
                if (!iwait) begin
                    m_valid[set_of(m_maddr)] = 1'b1;
                    m_tag[set_of(m_maddr)]   = tag_of(m_maddr);
                    m_data[set_of(m_maddr)]  = iload;
                    m_busy = 1'b0;
                end
            end else if (e_hit) begin
                m_hits = sat(m_hits);
            end else if (ren) begin
                m_busy  = 1'b1;
                m_maddr = addr;
                m_miss  = sat(m_miss);
            end
        end
        #1;
        chk_en = 1'b1;
    endtask

    logic [31:0] snap_h;
    logic [31:0] snap_m;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_data[i]  = 32'h0;
        end

        // 1: reset two cycles with a pending request; first edge brings DUT out of power-up
        cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h0);
        cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h0);
        check_eq("t1_iREN", {31'd0, mem_iREN}, 32'd0);
        check_eq("t1_hits", hit_count, 32'd0);

        // 2: cold miss @0x40, three wait cycles, then fill
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h2001_0005);
        check_eq("t2_iREN_after", {31'd0, mem_iREN}, 32'd0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("t2_hits", hit_count, 32'd1);
        check_eq("t2_miss", miss_count, 32'd1);

        // 3: conflict on set 0
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h8C00_0000);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("t3_miss", miss_count, 32'd3);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h2001_0005);

        // 4: invalidate with 0x40 resident, then inv on a fill-completion edge
        cycle(1'b0, 32'h40, 1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("t4_inv_miss", {31'd0, mem_iREN}, 32'd1);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h2001_0005);
        cycle(1'b1, 32'h84, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h84, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
        cycle(1'b1, 32'h84, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h2001_0005);
        cycle(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h8C00_0000);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h2001_0005);

        // 5: reset on the second FETCH cycle of a miss on 0x100
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        check_eq("t5_iREN_drop", {31'd0, mem_iREN}, 32'd0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("t5_refetch_miss", miss_count, 32'd1);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0000_0100);

        // 6: idle requests with arbitrary addresses
        snap_h = hit_count;
        snap_m = miss_count;
        for (int i = 0; i < 10; i++) cycle(1'b0, $urandom, 1'b0, 1'b0, 1'($urandom), $urandom);
        check_eq("t6_hits", hit_count, snap_h);
        check_eq("t6_miss", miss_count, snap_m);

        // Random traffic over a small address pool to mix hits, conflicts and misses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 3)) << 2)
                      + 32'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule
